dim_sched: RTL and testbench
============================

Name: dim_sched

Overview:
- Sequential, parametrised successor to the router's combinational per-dimension selector.
- Steps the current dimension through 0..NDIM-1 under control of the router sequencer.
- On each dimension, picks the highest-priority eligible message buffer and offers its index over a valid/ready handshake to the dimension output stage.
- Sits between the message buffer bank and the per-dimension send logic.

Parameters:
- NBUF, 7: number of message buffers, indexed 1..NBUF; index 0 is the "none" dummy.
- NDIM, 12: number of cube dimensions; address width per buffer.
- PRI_W, 3: priority width; priority 0 means never eligible.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- buf_valid  in  NBUF  bit i-1 set when buffer i holds a message
- buf_pri  in  NBUF*PRI_W  priority of buffer i in slice i-1
- buf_addr  in  NBUF*NDIM  relative address of buffer i in slice i-1; bit d set means the message must cross dimension d
- dim_step  in  1  strobe: advance to the next dimension
- send_ready  in  1  output stage accepts the offer
- cur_dim  out  $clog2(NDIM)  current dimension
- sel_valid  out  1  offer present
- sel_buf  out  $clog2(NBUF+1)  offered buffer index; 0 when sel_valid=0
- dim_wrap  out  1  one-cycle pulse when cur_dim wraps from NDIM-1 to 0

Behaviour:
- Eligibility of buffer i: buf_valid[i-1] & buf_addr[i-1][cur_dim] & (buf_pri[i-1] != 0).
- Selection:
  - The maximum priority among eligible buffers wins.
  - Ties go to the lowest index.
  - No eligible buffer gives index 0.
- Inputs are sampled only in SCAN. Later input changes do not alter a held offer.
- FSM states:
  - SCAN (one cycle): register the selection. If the index is nonzero, go to OFFER with sel_valid=1 next cycle; otherwise go to HOLD.
  - OFFER:
    - sel_valid=1 and sel_buf stay stable until transfer (sel_valid & send_ready).
    - On transfer, go to HOLD; sel_valid=0 next cycle.
  - HOLD: idle with sel_valid=0; wait for dim_step.
- dim_step in any state:
  - cur_dim <= (cur_dim==NDIM-1) ? 0 : cur_dim+1, effective next cycle.
  - Next state is SCAN.
  - dim_wrap=1 for the cycle in which cur_dim becomes 0.
- dim_step in OFFER without send_ready: the offer is abandoned, sel_valid=0 next cycle, and no transfer occurs.
- dim_step together with send_ready in OFFER: the transfer completes in that cycle and the dimension still advances.
- Latency: dim_step at cycle t gives cur_dim updated at t+1, SCAN at t+1, and sel_valid at t+2 at the earliest.
- At most one transfer per dimension visit.
- Reset values: cur_dim=0, sel_valid=0, sel_buf=0, dim_wrap=0, state=SCAN. Reset overrides dim_step and send_ready. A reset during OFFER drops the offer with no transfer.

Optional Feature:
- Macro: DIM_SCHED_RR_TIE_EN.
- Defined:
  - Ties are broken round-robin.
  - A pointer rr_last (reset 0) holds the index of the last transferred buffer.
  - Among equal-priority maxima, the first index strictly greater than rr_last wins, searching cyclically through 1..NBUF.
  - rr_last updates only on transfer.
- Undefined: fixed lowest-index tie-break and no pointer state.

Decomposition:
- Shared package router_pkg holds:
  - DIM_W = $clog2(NDIM) and IDX_W = $clog2(NBUF+1).
  - The FSM state enum {SCAN, OFFER, HOLD}.
  - The constant IDX_NONE = 0.
- One sub-module, dim_max_sel: a combinational log-depth comparator tree.
  - Takes masked priorities plus a tie-priority start index.
  - Returns the winning index.
  - Is parametrised on NBUF and PRI_W.

Test Plan:
- Reset, then idle with no dim_step → cur_dim=0, sel_valid=0, sel_buf=0 indefinitely.
- NBUF=7, cur_dim=0, buffers 2 and 5 valid with addr bit0=1, pri 3 and 6, send_ready=1 → sel_buf=5 valid two cycles after reset release, transfer, then HOLD with sel_valid=0.
- Buffers 3 and 4 both pri 4 with addr bit0=1 → without macro sel_buf=3. With DIM_SCHED_RR_TIE_EN: after transferring 3, a rescan of the same dimension (full wrap) offers 4.
- 12 dim_step strobes from cur_dim=0 → cur_dim runs 1..11 then 0, and dim_wrap is high exactly on the cycle cur_dim returns to 0.
- OFFER of buffer 6 with send_ready=0, dim_step asserted → no transfer, sel_valid=0 next cycle, cur_dim+1, SCAN selects for the new dimension. Repeat with send_ready=1 in the same cycle → one transfer counted.
- Eligible buffer whose pri=0, or whose addr bit is clear → sel_buf=0, sel_valid stays 0. Assert rst during OFFER → next cycle all outputs are zero.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router types and widths for the per-dimension scheduler.
// Optional round-robin tie-break: define DIM_SCHED_RR_TIE_EN.
package router_pkg;

  localparam int NBUF_DEF  = 7;
  localparam int NDIM_DEF  = 12;
  localparam int PRI_W_DEF = 3;

  localparam int DIM_W = $clog2(NDIM_DEF);
  localparam int IDX_W = $clog2(NBUF_DEF + 1);

  localparam logic [IDX_W-1:0] IDX_NONE = '0;

  typedef enum logic [1:0] {
    SCAN,
    OFFER,
    HOLD
  } state_e;

endpackage

// File: rtl/dim_max_sel.sv
// Combinational max-priority picker over buffers 1..NBUF, built as a
// balanced comparator tree with a cyclic tie-priority start index.
module dim_max_sel #(
  parameter  int NBUF  = 7,
  parameter  int PRI_W = 3,
  localparam int IW    = $clog2(NBUF + 1)
) (
  input  logic [NBUF*PRI_W-1:0] pri_i,
  input  logic [IW-1:0]         start_i,
  output logic [IW-1:0]         win_o
);

  localparam int LVL = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int N2  = 1 << LVL;

  // hi ranks indices at or after start_i ahead of wrapped-around ones
  typedef struct packed {
    logic [PRI_W-1:0] pri;
    logic             hi;
    logic [IW-1:0]    idx;
  } node_t;

  function automatic node_t best(input node_t a, input node_t b);
    logic a_wins;
    a_wins = (a.pri > b.pri) ||
             ((a.pri == b.pri) && (a.hi > b.hi)) ||
             ((a.pri == b.pri) && (a.hi == b.hi) && (a.idx < b.idx));
    return a_wins ? a : b;
  endfunction

  function automatic logic [IW-1:0] pick(
    input logic [NBUF*PRI_W-1:0] p,
    input logic [IW-1:0]         s
  );
    node_t nd [1:2*N2-1];
    for (int k = 0; k < N2; k++) begin
      nd[N2+k] = '0;
      if (k < NBUF) begin
        nd[N2+k].pri = p[k*PRI_W +: PRI_W];
        nd[N2+k].idx = IW'(k + 1);
        nd[N2+k].hi  = ((k + 1) >= int'(s));
      end
    end
    for (int k = N2 - 1; k >= 1; k--) begin
      nd[k] = best(nd[2*k], nd[2*k+1]);
    end
    return (nd[1].pri == '0) ? '0 : nd[1].idx;
  endfunction

  always_comb begin
    win_o = pick(pri_i, start_i);
  end

endmodule

// File: rtl/dim_sched.sv
// Sequential per-dimension buffer scheduler with valid/ready offer.
// Define DIM_SCHED_RR_TIE_EN for round-robin tie-breaking.
module dim_sched
  import router_pkg::*;
#(
  parameter  int NBUF  = NBUF_DEF,
  parameter  int NDIM  = NDIM_DEF,
  parameter  int PRI_W = PRI_W_DEF,
  localparam int DW    = $clog2(NDIM),
  localparam int IW    = $clog2(NBUF + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NBUF-1:0]       buf_valid,
  input  logic [NBUF*PRI_W-1:0] buf_pri,
  input  logic [NBUF*NDIM-1:0]  buf_addr,
  input  logic                  dim_step,
  input  logic                  send_ready,
  output logic [DW-1:0]         cur_dim,
  output logic                  sel_valid,
  output logic [IW-1:0]         sel_buf,
  output logic                  dim_wrap
);

  state_e          state_q, state_d;
  logic [DW-1:0]   cur_dim_q, cur_dim_d;
  logic [IW-1:0]   sel_buf_q, sel_buf_d;
  logic            wrap_q, wrap_d;
  logic [IW-1:0]   start;
  logic [IW-1:0]   win;
  logic            xfer;
  logic            last_dim;

  logic [NBUF*PRI_W-1:0] mpri;

  always_comb begin
    mpri = '0;
    for (int i = 0; i < NBUF; i++) begin
      logic [NDIM-1:0] a;
      a = buf_addr[i*NDIM +: NDIM];
      if (buf_valid[i] && a[cur_dim_q]) begin
        mpri[i*PRI_W +: PRI_W] = buf_pri[i*PRI_W +: PRI_W];
      end
    end
  end

`ifdef DIM_SCHED_RR_TIE_EN
  logic [IW-1:0] rr_last_q, rr_last_d;

  always_comb begin
    rr_last_d = xfer ? sel_buf_q : rr_last_q;
    start     = (rr_last_q == IW'(NBUF)) ? IW'(1)
                                         : rr_last_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= '0;
    else     rr_last_q <= rr_last_d;
  end
`else
  assign start = IW'(1);
`endif

  dim_max_sel #(
    .NBUF  (NBUF),
    .PRI_W (PRI_W)
  ) u_max (
    .pri_i   (mpri),
    .start_i (start),
    .win_o   (win)
  );

  assign xfer     = (state_q == OFFER) && send_ready;
  assign last_dim = (cur_dim_q == DW'(NDIM - 1));

  always_comb begin
    state_d   = state_q;
    sel_buf_d = sel_buf_q;
    cur_dim_d = cur_dim_q;
    wrap_d    = 1'b0;
    unique case (state_q)
      SCAN: begin
        sel_buf_d = win;
        state_d   = (win != IW'(IDX_NONE)) ? OFFER : HOLD;
      end
      OFFER: begin
        if (xfer) begin
          state_d   = HOLD;
          sel_buf_d = IW'(IDX_NONE);
        end
      end
      HOLD: ;
      default: begin
        state_d   = SCAN;
        sel_buf_d = IW'(IDX_NONE);
      end
    endcase
    // a step drops any held offer and rescans on the new dimension
    if (dim_step) begin
      state_d   = SCAN;
      sel_buf_d = IW'(IDX_NONE);
      cur_dim_d = last_dim ? '0 : cur_dim_q + DW'(1);
      wrap_d    = last_dim;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      cur_dim_q <= '0;
      sel_buf_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_dim_q <= cur_dim_d;
      sel_buf_q <= sel_buf_d;
      wrap_q    <= wrap_d;
    end
  end

  assign cur_dim   = cur_dim_q;
  assign sel_valid = (state_q == OFFER);
  assign sel_buf   = sel_buf_q;
  assign dim_wrap  = wrap_q;

endmodule

// File: tb/tb_dim_sched.sv
// Directed and randomised bench for dim_sched against a behavioural model.
module tb_dim_sched;

  localparam int NBUF  = 7;
  localparam int NDIM  = 12;
  localparam int PRI_W = 3;
  localparam int DW    = $clog2(NDIM);
  localparam int IW    = $clog2(NBUF + 1);

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NBUF-1:0]       buf_valid = '0;
  logic [NBUF*PRI_W-1:0] buf_pri = '0;
  logic [NBUF*NDIM-1:0]  buf_addr = '0;
  logic                  dim_step = 1'b0;
  logic                  send_ready = 1'b0;
  logic [DW-1:0]         cur_dim;
  logic                  sel_valid;
  logic [IW-1:0]         sel_buf;
  logic                  dim_wrap;

  always #5 clk = ~clk;

  dim_sched dut (
    .clk        (clk),
    .rst        (rst),
    .buf_valid  (buf_valid),
    .buf_pri    (buf_pri),
    .buf_addr   (buf_addr),
    .dim_step   (dim_step),
    .send_ready (send_ready),
    .cur_dim    (cur_dim),
    .sel_valid  (sel_valid),
    .sel_buf    (sel_buf),
    .dim_wrap   (dim_wrap)
  );

  int nvec = 0;
  int nerr = 0;

  int m_dim   = 0;
  int m_offer = 0;
  int m_rr    = 0;
  int m_xfers = 0;
  int d_xfers = 0;
  bit m_scan  = 1'b1;
  bit m_wrap  = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Best eligible buffer: highest priority, ties by cyclic distance past rr.
  function automatic int pick(input int dim, input int rr);
    int best = 0;
    int bpri = 0;
    int bd   = NBUF;
    for (int i = 1; i <= NBUF; i++) begin
      int p;
      int d;
      p = int'(buf_pri[(i-1)*PRI_W +: PRI_W]);
      if (buf_valid[i-1] && buf_addr[(i-1)*NDIM + dim] && p != 0) begin
        d = (i - rr - 1 + NBUF) % NBUF;
        if (p > bpri || (p == bpri && d < bd)) begin
          best = i;
          bpri = p;
          bd   = d;
        end
      end
    end
    return best;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_dim   = 0;
      m_offer = 0;
      m_rr    = 0;
      m_scan  = 1'b1;
      m_wrap  = 1'b0;
    end else begin
      if (sel_valid && send_ready) d_xfers++;
      if (m_offer != 0 && send_ready) begin
        m_xfers++;
        m_rr = m_offer;
      end
      if (dim_step) begin
        m_wrap  = (m_dim == NDIM - 1);
        m_dim   = (m_dim + 1) % NDIM;
        m_offer = 0;
        m_scan  = 1'b1;
      end else begin
        m_wrap = 1'b0;
        if (m_scan) begin
`ifdef DIM_SCHED_RR_TIE_EN
          m_offer = pick(m_dim, m_rr);
`else
          m_offer = pick(m_dim, 0);
`endif
          m_scan = 1'b0;
        end else if (m_offer != 0 && send_ready) begin
          m_offer = 0;
        end
      end
    end
    #1;
    chk("cur_dim", int'(cur_dim), m_dim);
    chk("sel_valid", int'(sel_valid), (m_offer != 0) ? 1 : 0);
    chk("sel_buf", int'(sel_buf), m_offer);
    chk("dim_wrap", int'(dim_wrap), int'(m_wrap));
    chk("xfers", d_xfers, m_xfers);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    buf_valid = '0;
    buf_pri   = '0;
    buf_addr  = '0;
  endtask

  task automatic setb(input int i, input int p, input logic [NDIM-1:0] a);
    buf_valid[i-1] = 1'b1;
    buf_pri[(i-1)*PRI_W +: PRI_W] = PRI_W'(p);
    buf_addr[(i-1)*NDIM +: NDIM]  = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  int x0;

  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(6);
    chk("idle_dim", int'(cur_dim), 0);
    chk("idle_valid", int'(sel_valid), 0);
    chk("idle_buf", int'(sel_buf), 0);

    setb(2, 3, 12'h001);
    setb(5, 6, 12'h001);
    send_ready = 1'b1;
    do_reset();
    cyc(1);
    chk("max_valid", int'(sel_valid), 1);
    chk("max_buf", int'(sel_buf), 5);
    cyc(1);
    chk("post_xfer_valid", int'(sel_valid), 0);
    chk("post_xfer_buf", int'(sel_buf), 0);

    clr();
    setb(3, 4, 12'h001);
    setb(4, 4, 12'h001);
    do_reset();
    cyc(1);
    chk("tie_first", int'(sel_buf), 3);
    cyc(1);
    dim_step = 1'b1;
    for (int k = 1; k <= NDIM; k++) begin
      cyc(1);
      chk("walk_dim", int'(cur_dim), k % NDIM);
      chk("walk_wrap", int'(dim_wrap), (k == NDIM) ? 1 : 0);
    end
    dim_step = 1'b0;
    cyc(1);
    chk("wrap_clear", int'(dim_wrap), 0);
`ifdef DIM_SCHED_RR_TIE_EN
    chk("tie_rescan", int'(sel_buf), 4);
`else
    chk("tie_rescan", int'(sel_buf), 3);
`endif
    cyc(1);

    clr();
    setb(6, 5, 12'hFFF);
    send_ready = 1'b0;
    do_reset();
    cyc(1);
    chk("abandon_offer", int'(sel_buf), 6);
    x0 = d_xfers;
    dim_step = 1'b1;
    cyc(1);
    dim_step = 1'b0;
    chk("abandon_valid", int'(sel_valid), 0);
    chk("abandon_dim", int'(cur_dim), 1);
    cyc(1);
    chk("rescan_buf", int'(sel_buf), 6);
    cyc(2);
    chk("held_valid", int'(sel_valid), 1);
    chk("no_xfer", d_xfers - x0, 0);
    dim_step = 1'b1;
    send_ready = 1'b1;
    cyc(1);
    dim_step = 1'b0;
    send_ready = 1'b0;
    chk("step_xfer", d_xfers - x0, 1);
    chk("step_xfer_dim", int'(cur_dim), 2);
    cyc(1);

    clr();
    setb(1, 0, 12'hFFF);
    setb(2, 7, 12'h002);
    do_reset();
    cyc(3);
    chk("inelig_valid", int'(sel_valid), 0);
    chk("inelig_buf", int'(sel_buf), 0);
    setb(2, 7, 12'h001);
    do_reset();
    cyc(1);
    chk("pre_rst_buf", int'(sel_buf), 2);
    rst = 1'b1;
    dim_step = 1'b1;
    send_ready = 1'b1;
    cyc(1);
    chk("rst_dim", int'(cur_dim), 0);
    chk("rst_valid", int'(sel_valid), 0);
    chk("rst_buf", int'(sel_buf), 0);
    chk("rst_wrap", int'(dim_wrap), 0);
    rst = 1'b0;
    dim_step = 1'b0;
    send_ready = 1'b0;

    for (int n = 0; n < 80; n++) begin
      buf_valid  = NBUF'($urandom);
      buf_pri    = (NBUF*PRI_W)'($urandom);
      buf_addr   = {$urandom, $urandom, $urandom};
      dim_step   = ($urandom_range(0, 3) == 0);
      send_ready = $urandom_range(0, 1) == 1;
      cyc(1);
    end
    dim_step = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
